// File: rtl/input_cond_pkg.sv
// input_cond_pkg: shared defaults and counter-width helper for the input conditioner
package input_cond_pkg;
  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int PRESCALE_DEF = 1;
  // A counter that must reach n-1 needs $clog2(n) bits; keep at least one bit so n=1 still elaborates.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/debounce_ch.sv
// debounce_ch: one channel's two-flop synchroniser, debounce counter, level and rise/fall strobes
// ports: clk, reset (async active-low), tick (sample enable), raw_in (async level),
//        level (debounced), rise/fall (one-cycle strobes on level change)
module debounce_ch
  import input_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic raw_in,
  output logic level,
  output logic rise,
  output logic fall
);
  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic s1_q, s2_q, level_q, level_d, rise_q, rise_d, fall_q, fall_d, mismatch, done;
  logic [CW-1:0] cnt_q, cnt_d;
  // done marks the tick that completes a full run of mismatching samples; strobes derive from it
  // so they coincide with the first cycle the new level is visible.
  always_comb begin
    mismatch = s2_q ^ level_q;
    done     = tick & mismatch & (cnt_q == LAST);
    cnt_d    = !tick ? cnt_q : (!mismatch || done) ? '0 : cnt_q + 1'b1;
    level_d  = done ? s2_q : level_q;
    rise_d   = done & s2_q;
    fall_d   = done & ~s2_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      s1_q    <= raw_in;
      s2_q    <= s1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end
  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;
endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: synchronises and debounces WIDTH raw inputs with a shared sample-tick prescaler
// ports: clk, reset (async active-low), raw_in[WIDTH] (async levels),
//        level[WIDTH] (debounced), rise/fall[WIDTH] (one-cycle strobes)
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int PRESCALE        = PRESCALE_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);
  localparam int PW = cnt_width(PRESCALE);
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic tick;
  // With PRESCALE=1 the counter is pinned at 0 and tick stays high every cycle.
  always_comb begin
    tick   = pcnt_q == PW'(PRESCALE - 1);
    pcnt_d = tick ? '0 : pcnt_q + 1'b1;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pcnt_q <= '0;
    else pcnt_q <= pcnt_d;
  end
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch (
      .clk   (clk),
      .reset (reset),
      .tick  (tick),
      .raw_in(raw_in[i]),
      .level (level[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );
  end
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed scenarios plus random stimulus against a run-length reference model
module tb_input_conditioner;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] raw_in = 2'b00;
  logic [1:0] level, rise, fall, level_p, rise_p, fall_p;
  int checks = 0;
  int errors = 0;

  input_conditioner dut (
    .clk(clk), .reset(reset), .raw_in(raw_in), .level(level), .rise(rise), .fall(fall)
  );
  input_conditioner #(.WIDTH(2), .DEBOUNCE_CYCLES(3), .PRESCALE(4)) dut_p (
    .clk(clk), .reset(reset), .raw_in(raw_in), .level(level_p), .rise(rise_p), .fall(fall_p)
  );

  always #5 clk = ~clk;

  // Reference: input seen two edges late; a sample tick every P cycles (first at cycle P);
  // level flips once D consecutive ticks have seen the opposite value.
  int pm[2] = '{1, 4};
  int dm[2] = '{4, 3};
  logic [1:0] m_d1 = 0, m_d2 = 0, m_seen;
  logic [1:0] m_lvl[2] = '{2'b00, 2'b00};
  logic [1:0] m_rise[2] = '{2'b00, 2'b00};
  logic [1:0] m_fall[2] = '{2'b00, 2'b00};
  int m_cyc = 0;
  int m_run[2][2];
  bit m_tick;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_d1 = 0;
      m_d2 = 0;
      m_cyc = 0;
      for (int k = 0; k < 2; k++) begin
        m_lvl[k] = 0;
        m_rise[k] = 0;
        m_fall[k] = 0;
        for (int i = 0; i < 2; i++) m_run[k][i] = 0;
      end
    end else begin
      m_seen = m_d2;
      m_d2 = m_d1;
      m_d1 = raw_in;
      m_cyc++;
      for (int k = 0; k < 2; k++) begin
        m_tick = (m_cyc % pm[k]) == 0;
        m_rise[k] = 0;
        m_fall[k] = 0;
        if (m_tick) begin
          for (int i = 0; i < 2; i++) begin
            if (m_seen[i] == m_lvl[k][i]) m_run[k][i] = 0;
            else begin
              m_run[k][i]++;
              if (m_run[k][i] == dm[k]) begin
                m_lvl[k][i] = m_seen[i];
                m_rise[k][i] = m_seen[i];
                m_fall[k][i] = ~m_seen[i];
                m_run[k][i] = 0;
              end
            end
          end
        end
      end
    end
  end

  logic [11:0] got_all, want_all;
  assign got_all  = {level, rise, fall, level_p, rise_p, fall_p};
  assign want_all = {m_lvl[0], m_rise[0], m_fall[0], m_lvl[1], m_rise[1], m_fall[1]};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    raw_in = 2'b11;
    reset = 1'b0;
    repeat (3) begin
      step();
      checks++;
      if (got_all !== 12'b0) begin
        errors++;
        $display("FAIL reset_outputs got %b want %b", got_all, 12'b0);
      end
    end
  endtask

  task automatic test_clean_rise();
    logic [5:0] want;
    reset = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      step();
      want = (n < 6) ? 6'b00_00_00 : (n == 6) ? 6'b11_11_00 : 6'b11_00_00;
      checks++;
      if ({level, rise, fall} !== want) begin
        errors++;
        $display("FAIL clean_rise edge %0d got %b want %b", n, {level, rise, fall}, want);
      end
      checks++;
      if (got_all !== want_all) begin
        errors++;
        $display("FAIL model_clean_rise got %b want %b", got_all, want_all);
      end
    end
  endtask

  task automatic test_glitch();
    int nr, nf;
    raw_in = 2'b10;
    repeat (8) begin
      step();
      checks++;
      if (got_all !== want_all) begin
        errors++;
        $display("FAIL model_glitch_setup got %b want %b", got_all, want_all);
      end
    end
    for (int n = 0; n < 13; n++) begin
      raw_in = (n < 3) ? 2'b11 : 2'b10;
      step();
      checks++;
      if ({level[0], rise[0], fall[0]} !== 3'b000) begin
        errors++;
        $display("FAIL glitch_reject cycle %0d got %b want 000", n, {level[0], rise[0], fall[0]});
      end
      checks++;
      if (got_all !== want_all) begin
        errors++;
        $display("FAIL model_glitch got %b want %b", got_all, want_all);
      end
    end
    nr = 0;
    nf = 0;
    for (int n = 0; n < 16; n++) begin
      raw_in = (n < 6) ? 2'b11 : 2'b10;
      step();
      nr += int'(rise[0]);
      nf += int'(fall[0]);
      checks++;
      if (got_all !== want_all) begin
        errors++;
        $display("FAIL model_long_pulse got %b want %b", got_all, want_all);
      end
    end
    checks++;
    if (nr != 1 || nf != 1) begin
      errors++;
      $display("FAIL long_pulse_strobes rise %0d fall %0d want 1 1", nr, nf);
    end
  endtask

  task automatic test_fall();
    logic [2:0] want;
    raw_in = 2'b00;
    for (int n = 1; n <= 8; n++) begin
      step();
      want = {n < 6, n == 6, 1'b0};
      checks++;
      if ({level[1], fall[1], rise[1]} !== want) begin
        errors++;
        $display("FAIL fall_strobe edge %0d got %b want %b", n, {level[1], fall[1], rise[1]}, want);
      end
      checks++;
      if (got_all !== want_all) begin
        errors++;
        $display("FAIL model_fall got %b want %b", got_all, want_all);
      end
    end
  endtask

  task automatic test_independent();
    logic [3:0] want;
    raw_in = 2'b10;
    repeat (16) step();
    raw_in = 2'b01;
    for (int n = 1; n <= 8; n++) begin
      step();
      want = (n == 6) ? 4'b01_10 : 4'b00_00;
      checks++;
      if ({rise, fall} !== want) begin
        errors++;
        $display("FAIL independent edge %0d got %b want %b", n, {rise, fall}, want);
      end
      checks++;
      if (got_all !== want_all) begin
        errors++;
        $display("FAIL model_independent got %b want %b", got_all, want_all);
      end
    end
  endtask

  task automatic test_prescale();
    int n;
    raw_in = 2'b00;
    repeat (30) step();
    for (int dir = 1; dir >= 0; dir--) begin
      raw_in = 2'(dir);
      n = 0;
      do begin
        step();
        n++;
        checks++;
        if (got_all !== want_all) begin
          errors++;
          $display("FAIL model_prescale got %b want %b", got_all, want_all);
        end
      end while (level_p[0] !== 1'(dir) && n < 40);
      checks++;
      if (n < 11 || n > 17 || {rise_p[0], fall_p[0]} !== {1'(dir), ~1'(dir)}) begin
        errors++;
        $display("FAIL prescale_latency dir %0d edges %0d strobes %b want 11..17", dir, n, {rise_p[0], fall_p[0]});
      end
      step();
      checks++;
      if ({level_p[0], rise_p[0], fall_p[0]} !== {1'(dir), 2'b00}) begin
        errors++;
        $display("FAIL prescale_strobe_width dir %0d got %b", dir, {level_p[0], rise_p[0], fall_p[0]});
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] want;
    raw_in = 2'b10;
    repeat (30) step();
    raw_in = 2'b11;
    repeat (4) step();
    reset = 1'b0;
    #1;
    checks++;
    if (got_all !== 12'b0) begin
      errors++;
      $display("FAIL reset_async got %b want %b", got_all, 12'b0);
    end
    step();
    reset = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      step();
      want = (n < 6) ? 4'b00_00 : (n == 6) ? 4'b11_11 : 4'b11_00;
      checks++;
      if ({level, rise} !== want) begin
        errors++;
        $display("FAIL reset_mid edge %0d got %b want %b", n, {level, rise}, want);
      end
      checks++;
      if (got_all !== want_all) begin
        errors++;
        $display("FAIL model_reset_mid got %b want %b", got_all, want_all);
      end
    end
  endtask

  task automatic test_random();
    repeat (60) begin
      raw_in = 2'($urandom_range(0, 3));
      repeat ($urandom_range(1, 14)) begin
        step();
        checks++;
        if (got_all !== want_all) begin
          errors++;
          $display("FAIL model_random raw %b got %b want %b", raw_in, got_all, want_all);
        end
      end
    end
  endtask

  initial begin
    #2 reset = 1'b0;
    test_reset();
    test_clean_rise();
    test_glitch();
    test_fall();
    test_independent();
    test_prescale();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
